bus_sram: RTL and testbench

Block-RAM responder on the main bus: a slave port behind the main bus interconnect, serving a word-addressed on-chip scratchpad. It accepts one command at a time on the command channel and either streams a fixed-length wrapping read burst or absorbs a master-terminated byte-masked write burst. Out-of-range accesses are reported on the error channel.

---
 rtl/bus_sram.sv | 174 +++++++++++++++++
 tb/tb_bus_sram.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sram.sv
// bus_sram: block-RAM responder on the main bus.
// A word-addressed on-chip scratchpad that accepts one command at a time.
// A read command streams a fixed-length, critical-word-first wrapping burst.
// A write command absorbs a master-terminated, byte-masked write burst.
// Accesses outside the array are reported on the error channel.
//
// Ports:
//   clk_core, reset_n          core clock, async active-low reset
//   bmain_cvalid_sram/sram_cready, bmain_cmd, bmain_addr
//                              command channel (cmd 1 = read, addr = byte addr [27:2])
//   bmain_wvalid_sram/sram_wready, bmain_wlast, bmain_wdata, bmain_wmask
//                              write data channel
//   sram_rvalid/bmain_rready_sram, sram_rlast, sram_rdata
//                              read data channel
//   sram_error/bmain_eack_sram access fault flag and its acknowledge
module bus_sram #(
  parameter int ADDR_BITS   = 12,
  parameter int BURST_BEATS = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        bmain_cvalid_sram,
  output logic        sram_cready,
  input  logic        bmain_cmd,
  input  logic [25:0] bmain_addr,
  input  logic        bmain_wvalid_sram,
  output logic        sram_wready,
  input  logic        bmain_wlast,
  input  logic [31:0] bmain_wdata,
  input  logic [3:0]  bmain_wmask,
  output logic        sram_rvalid,
  input  logic        bmain_rready_sram,
  output logic        sram_rlast,
  output logic [31:0] sram_rdata,
  output logic        sram_error,
  input  logic        bmain_eack_sram
);

  // One extra bit so the read issue count can reach BURST_BEATS itself.
  localparam int CNT_W = $clog2(BURST_BEATS) + 1;
  localparam logic [ADDR_BITS-1:0] WRAP_MASK = ADDR_BITS'(BURST_BEATS - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(BURST_BEATS);

  typedef enum logic [2:0] {IDLE, READ, WRITE, WDRAIN, ERROR} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] cmd_idx;
  logic [ADDR_BITS-1:0] beat_addr;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic [31:0]          mem [2**ADDR_BITS];

  logic cmd_beat;
  logic in_range;
  logic rd_issue;
  logic rd_beat;
  logic wr_beat;
  logic ram_we;

  assign in_range = (bmain_addr[25:ADDR_BITS] == '0);
  assign cmd_beat = bmain_cvalid_sram & sram_cready;
  assign rd_beat  = rvalid_q & bmain_rready_sram;
  assign wr_beat  = bmain_wvalid_sram & sram_wready;
  assign ram_we   = wr_beat & (state == WRITE);

  // Upper index bits stay fixed from the command; the low bits advance with
  // the beat count modulo the burst length, wrapping inside the aligned block.
  // The write count may exceed the burst length, the mask takes care of it.
  assign beat_addr = (cmd_idx & ~WRAP_MASK) |
                     ((cmd_idx + ADDR_BITS'(beat_cnt)) & WRAP_MASK);

  // A new read may be launched whenever the output slot is empty or is being
  // emptied this cycle, which gives back-to-back beats with no bubble.
  assign rd_issue = (state == READ) && (beat_cnt < CNT_FULL) &&
                    (!rvalid_q || bmain_rready_sram);

  // The beat on the output is always the most recently issued one, so the
  // final beat is showing exactly when the issue count has reached the burst.
  assign sram_rvalid = rvalid_q;
  assign sram_rlast  = rvalid_q && (beat_cnt == CNT_FULL);
  assign sram_rdata  = rdata_q;

  // State register.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state handshake outputs.
  always_comb begin
    state_nxt   = state;
    sram_cready = 1'b0;
    sram_wready = 1'b0;
    sram_error  = 1'b0;
    unique case (state)
      IDLE: begin
        sram_cready = 1'b1;
        if (bmain_cvalid_sram) begin
          if (bmain_cmd) begin
            state_nxt = in_range ? READ : ERROR;
          end else begin
            state_nxt = in_range ? WRITE : WDRAIN;
          end
        end
      end
      READ: begin
        if (rd_beat && sram_rlast) begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        sram_wready = 1'b1;
        if (bmain_wvalid_sram && bmain_wlast) begin
          state_nxt = IDLE;
        end
      end
      WDRAIN: begin
        sram_wready = 1'b1;
        if (bmain_wvalid_sram && bmain_wlast) begin
          state_nxt = ERROR;
        end
      end
      ERROR: begin
        sram_error = 1'b1;
        if (bmain_eack_sram) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, beat counter and read-valid flag. The counter is shared
  // between read issues and write beats because only one burst is ever open.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      cmd_idx  <= '0;
      beat_cnt <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (cmd_beat) begin
        cmd_idx  <= bmain_addr[ADDR_BITS-1:0];
        beat_cnt <= '0;
      end else if (rd_issue || wr_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (rd_issue) begin
        rvalid_q <= 1'b1;
      end else if (rd_beat) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Scratchpad array: synchronous read with enable, byte-masked write.
  // The read register is not reset so it maps onto the block-RAM output latch.
  always_ff @(posedge clk_core) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bmain_wmask[b]) begin
          mem[beat_addr][8*b +: 8] <= bmain_wdata[8*b +: 8];
        end
      end
    end
    if (rd_issue) begin
      rdata_q <= mem[beat_addr];
    end
  end

endmodule

// File: tb/tb_bus_sram.sv
// tb_bus_sram: self-checking bench for bus_sram.
// A table of directed transactions covers the basic read, wrap, byte-mask,
// backpressure and fault cases; hand-written sequences cover reset behaviour;
// a random phase checks reads against a word-array model of the scratchpad.
module tb_bus_sram;

  localparam int AB = 12;
  localparam int BB = 4;

  logic        clk_core;
  logic        reset_n;
  logic        bmain_cvalid_sram;
  logic        sram_cready;
  logic        bmain_cmd;
  logic [25:0] bmain_addr;
  logic        bmain_wvalid_sram;
  logic        sram_wready;
  logic        bmain_wlast;
  logic [31:0] bmain_wdata;
  logic [3:0]  bmain_wmask;
  logic        sram_rvalid;
  logic        bmain_rready_sram;
  logic        sram_rlast;
  logic [31:0] sram_rdata;
  logic        sram_error;
  logic        bmain_eack_sram;

  int checks = 0;
  int errors = 0;

  // Reference image of the array, indexed by word.
  logic [31:0] model [2**AB];

  typedef struct {
    bit               is_read;
    logic [25:0]      addr;
    int               nbeats;
    logic [5:0][31:0] wdata;
    logic [5:0][3:0]  wmask;
    int               rmode;
    logic [3:0][31:0] rexp;
    bit               exp_err;
  } vec_t;

  vec_t tbl [9];

  bus_sram #(.ADDR_BITS(AB), .BURST_BEATS(BB)) dut (
    .clk_core          (clk_core),
    .reset_n           (reset_n),
    .bmain_cvalid_sram (bmain_cvalid_sram),
    .sram_cready       (sram_cready),
    .bmain_cmd         (bmain_cmd),
    .bmain_addr        (bmain_addr),
    .bmain_wvalid_sram (bmain_wvalid_sram),
    .sram_wready       (sram_wready),
    .bmain_wlast       (bmain_wlast),
    .bmain_wdata       (bmain_wdata),
    .bmain_wmask       (bmain_wmask),
    .sram_rvalid       (sram_rvalid),
    .bmain_rready_sram (bmain_rready_sram),
    .sram_rlast        (sram_rlast),
    .sram_rdata        (sram_rdata),
    .sram_error        (sram_error),
    .bmain_eack_sram   (bmain_eack_sram)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Word index of beat k of a burst starting at base: same aligned block,
  // offset advancing modulo the burst length.
  function automatic int burst_idx(input int base, input int k);
    return (base / BB) * BB + ((base % BB) + k) % BB;
  endfunction

  task automatic issue_cmd(input bit rd, input logic [25:0] addr, input string tag);
    int budget;
    budget = 20;
    bmain_cvalid_sram = 1'b1;
    bmain_cmd         = rd;
    bmain_addr        = addr;
    while (!sram_cready && budget > 0) begin
      tick();
      budget--;
    end
    check_output({tag, "_cready"}, 32'(sram_cready), 32'd1);
    tick();
    bmain_cvalid_sram = 1'b0;
  endtask

  task automatic ack_error(input string tag);
    check_output({tag, "_error"}, 32'(sram_error), 32'd1);
    check_output({tag, "_no_rvalid"}, 32'(sram_rvalid), 32'd0);
    bmain_eack_sram = 1'b1;
    tick();
    bmain_eack_sram = 1'b0;
    check_output({tag, "_error_clr"}, 32'(sram_error), 32'd0);
    check_output({tag, "_idle"}, 32'(sram_cready), 32'd1);
  endtask

  // rmode: 0 = rready always high, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic do_read(input logic [25:0] addr, input int rmode, input logic [3:0][31:0] rexp,
                         input bit exp_err, input string tag);
    int          cyc;
    int          beats;
    int          first;
    bit          stalled;
    logic [31:0] held;
    cyc = 0; beats = 0; first = -1; stalled = 0; held = '0;
    issue_cmd(1'b1, addr, tag);
    if (exp_err) begin
      for (int i = 0; i < 3; i++) begin
        check_output({tag, "_err_hold"}, 32'(sram_error), 32'd1);
        check_output({tag, "_err_no_rvalid"}, 32'(sram_rvalid), 32'd0);
        tick();
      end
      ack_error(tag);
      return;
    end
    while (beats < BB && cyc < 60) begin
      case (rmode)
        0:       bmain_rready_sram = 1'b1;
        1:       bmain_rready_sram = (cyc % 3 == 0);
        default: bmain_rready_sram = 1'($urandom_range(0, 1));
      endcase
      if (sram_rvalid) begin
        if (first < 0) first = cyc;
        if (stalled) check_output({tag, "_stall_hold"}, sram_rdata, held);
        if (bmain_rready_sram) begin
          check_output({tag, "_rdata"}, sram_rdata, rexp[beats]);
          check_output({tag, "_rlast"}, 32'(sram_rlast), 32'(beats == BB - 1));
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = sram_rdata;
        end
      end
      tick();
      cyc++;
    end
    bmain_rready_sram = 1'b0;
    check_output({tag, "_beats"}, 32'(beats), 32'(BB));
    if (rmode == 0) begin
      check_output({tag, "_first_rvalid"}, 32'(first), 32'd1);
      check_output({tag, "_no_gaps"}, 32'(cyc), 32'(BB + 1));
    end
    check_output({tag, "_end_cready"}, 32'(sram_cready), 32'd1);
    check_output({tag, "_end_rvalid"}, 32'(sram_rvalid), 32'd0);
  endtask

  task automatic do_write(input logic [25:0] addr, input int n, input logic [5:0][31:0] d,
                          input logic [5:0][3:0] m, input bit exp_err, input string tag);
    int budget;
    issue_cmd(1'b0, addr, tag);
    check_output({tag, "_wready_t1"}, 32'(sram_wready), 32'd1);
    for (int k = 0; k < n; k++) begin
      bmain_wvalid_sram = 1'b1;
      bmain_wdata       = d[k];
      bmain_wmask       = m[k];
      bmain_wlast       = (k == n - 1);
      budget = 20;
      while (!sram_wready && budget > 0) begin
        tick();
        budget--;
      end
      tick();
    end
    bmain_wvalid_sram = 1'b0;
    bmain_wlast       = 1'b0;
    if (exp_err) begin
      check_output({tag, "_no_cready"}, 32'(sram_cready), 32'd0);
      ack_error(tag);
    end else begin
      for (int k = 0; k < n; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (m[k][b]) model[burst_idx(int'(addr[AB-1:0]), k)][8*b +: 8] = d[k][8*b +: 8];
        end
      end
      check_output({tag, "_idle"}, 32'(sram_cready), 32'd1);
      check_output({tag, "_wready_off"}, 32'(sram_wready), 32'd0);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    if (v.is_read) do_read(v.addr, v.rmode, v.rexp, v.exp_err, tag);
    else           do_write(v.addr, v.nbeats, v.wdata, v.wmask, v.exp_err, tag);
  endtask

  task automatic random_phase();
    logic [5:0][31:0] d;
    logic [5:0][3:0]  m;
    logic [3:0][31:0] e;
    logic [25:0]      a;
    int               r;
    int               n;
    // Preload words 0..31 with full-mask bursts so every read has a known image.
    for (int blk = 0; blk < 8; blk++) begin
      for (int k = 0; k < 6; k++) begin
        d[k] = $urandom;
        m[k] = 4'hF;
      end
      do_write(26'(blk * BB), BB, d, m, 1'b0, "preload");
    end
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        a = 26'($urandom) | 26'(1 << ($urandom_range(AB, 25)));
        for (int k = 0; k < 6; k++) begin
          d[k] = $urandom;
          m[k] = 4'hF;
        end
        if (r == 0) do_read(a, 2, e, 1'b1, "rnd_oor_rd");
        else        do_write(a, int'($urandom_range(1, 3)), d, m, 1'b1, "rnd_oor_wr");
      end else if (r < 6) begin
        a = 26'($urandom_range(0, 31));
        for (int k = 0; k < BB; k++) e[k] = model[burst_idx(int'(a), k)];
        do_read(a, 2, e, 1'b0, "rnd_rd");
      end else begin
        a = 26'($urandom_range(0, 31));
        n = $urandom_range(1, 6);
        for (int k = 0; k < 6; k++) begin
          d[k] = $urandom;
          m[k] = 4'($urandom_range(0, 15));
        end
        do_write(a, n, d, m, 1'b0, "rnd_wr");
      end
    end
  endtask

  initial begin
    int beats;
    int budget;

    // Directed table; packed arrays list the last element first.
    tbl[0] = '{0, 26'h10, 4, {32'h0, 32'h0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
               {4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF}, 0, '0, 0};
    tbl[1] = '{1, 26'h10, 0, '0, '0, 0,
               {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 0};
    tbl[2] = '{1, 26'h12, 0, '0, '0, 0,
               {32'h22222222, 32'h11111111, 32'h44444444, 32'h33333333}, 0};
    tbl[3] = '{0, 26'h13, 1, {160'h0, 32'hAABBCCDD}, {20'h0, 4'b0101}, 0, '0, 0};
    tbl[4] = '{1, 26'h13, 0, '0, '0, 0,
               {32'h33333333, 32'h22222222, 32'h11111111, 32'h44BB44DD}, 0};
    tbl[5] = '{1, 26'h10, 0, '0, '0, 1,
               {32'h44BB44DD, 32'h33333333, 32'h22222222, 32'h11111111}, 0};
    tbl[6] = '{1, 26'h4000, 0, '0, '0, 0, '0, 1};
    tbl[7] = '{0, 26'h4010, 2, {128'h0, 32'hCAFEF00D, 32'hDEADBEEF},
               {16'h0, 4'hF, 4'hF}, 0, '0, 1};
    tbl[8] = '{1, 26'h10, 0, '0, '0, 0,
               {32'h44BB44DD, 32'h33333333, 32'h22222222, 32'h11111111}, 0};

    reset_n = 1'b0;
    bmain_cvalid_sram = 0; bmain_cmd = 0; bmain_addr = '0;
    bmain_wvalid_sram = 0; bmain_wlast = 0; bmain_wdata = '0; bmain_wmask = '0;
    bmain_rready_sram = 0; bmain_eack_sram = 0;
    for (int i = 0; i < (2**AB); i++) model[i] = '0;

    #12;
    check_output("reset_cready", 32'(sram_cready), 32'd1);
    check_output("reset_wready", 32'(sram_wready), 32'd0);
    check_output("reset_rvalid", 32'(sram_rvalid), 32'd0);
    check_output("reset_rlast", 32'(sram_rlast), 32'd0);
    check_output("reset_error", 32'(sram_error), 32'd0);
    @(negedge clk_core);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) apply_stimulus(tbl[i], $sformatf("vec%0d", i));

    // Reset between read beats 2 and 3.
    issue_cmd(1'b1, 26'h10, "rst_mid");
    bmain_rready_sram = 1'b1;
    beats  = 0;
    budget = 20;
    while (beats < 2 && budget > 0) begin
      if (sram_rvalid) beats++;
      tick();
      budget--;
    end
    bmain_rready_sram = 1'b0;
    check_output("rst_mid_beats", 32'(beats), 32'd2);
    check_output("rst_mid_pending", 32'(sram_rvalid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_mid_rvalid_async", 32'(sram_rvalid), 32'd0);
    check_output("rst_mid_rlast_async", 32'(sram_rlast), 32'd0);
    tick();
    tick();
    @(negedge clk_core);
    reset_n = 1'b1;
    tick();
    check_output("rst_mid_cready", 32'(sram_cready), 32'd1);
    check_output("rst_mid_rvalid", 32'(sram_rvalid), 32'd0);
    apply_stimulus(tbl[8], "rst_mid_reread");

    random_phase();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
